// File: rtl/seq_divider.sv
// Unsigned restoring divider that produces one quotient bit per clock.
// A zero divisor skips the iteration and reports all-ones quotient with the dividend as remainder.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;      // remaining dividend bits, consumed MSB first
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] prem_q, prem_d;    // working remainder
    logic [WIDTH-1:0] pquo_q, pquo_d;    // working quotient
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             q_bit;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    // The shifted remainder can reach 2*divisor-1, so the compare needs one extra bit.
    always_comb begin
        shifted  = {prem_q, dvd_q[WIDTH-1]};
        diff     = shifted - {1'b0, dvs_q};
        q_bit    = (shifted >= {1'b0, dvs_q});
        rem_step = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_step = {pquo_q[WIDTH-2:0], q_bit};
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        pquo_d  = pquo_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        dvd_d   = dividend;
                        dvs_d   = divisor;
                        cnt_d   = CNT_W'(WIDTH);
                        prem_d  = '0;
                        pquo_d  = '0;
                        state_d = RUN;
                    end else begin
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
                prem_d = rem_step;
                pquo_d = quo_step;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    quo_d   = quo_step;
                    rem_d   = rem_step;
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            pquo_q  <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            pquo_q  <= pquo_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: table vectors, reset abort, back-to-back issue and random pairs,
// with expected results queued at issue and compared when done pulses.
module tb_seq_divider;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    seq_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } vec_t;

    res_t   sb[$];
    int     total = 0;
    int     bad = 0;
    longint cyc = 0;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t r;
        if (b == '0) begin
            r.q = '1; r.r = a; r.dbz = 1'b1;
        end else begin
            r.q = a / b; r.r = a % b; r.dbz = 1'b0;
        end
        return r;
    endfunction

    function automatic res_t mk(input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz);
        res_t e;
        e.q = q; e.r = r; e.dbz = dbz;
        return e;
    endfunction

    task automatic check_result(input string tag);
        res_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s: got=done_pulse want=no_pending_op", tag);
        end else begin
            total--;
            e = sb.pop_front();
            chk({tag, " quotient"}, 64'(quotient), 64'(e.q));
            chk({tag, " remainder"}, 64'(remainder), 64'(e.r));
            chk({tag, " div_by_zero"}, 64'(div_by_zero), 64'(e.dbz));
            $display("op %s: q=%0h r=%0h dbz=%0b", tag, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input res_t exp);
        int           n;
        int           exp_lat;
        logic [W-1:0] q0, r0;
        logic         held, busy_ok;
        exp_lat  = (b == '0) ? 0 : W;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(exp);
        q0 = quotient;
        r0 = remainder;
        step();
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        n = 0; held = 1'b1; busy_ok = 1'b1;
        while (!done && n < W + 10) begin
            if (quotient !== q0 || remainder !== r0) held = 1'b0;
            if (!busy) busy_ok = 1'b0;
            step();
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'(exp_lat));
        chk({tag, " outputs_held"}, 64'(held), 64'(1));
        chk({tag, " busy_in_run"}, 64'(busy_ok), 64'(1));
        if (done) check_result(tag);
        else void'(sb.pop_front());
        step();
        chk({tag, " done_width"}, 64'(done), 64'(0));
        chk({tag, " idle_busy"}, 64'(busy), 64'(0));
    endtask

    initial begin
        vec_t         vecs[11];
        int           n, dn;
        longint       t1, t2;
        logic [W-1:0] a, b;

        vecs[0]  = '{a: 32'd100,        b: 32'd7,          q: 32'd14,         r: 32'd2,          dbz: 1'b0};
        vecs[1]  = '{a: 32'hFFFF_FFFF,  b: 32'd1,          q: 32'hFFFF_FFFF,  r: 32'd0,          dbz: 1'b0};
        vecs[2]  = '{a: 32'h8000_0000,  b: 32'hFFFF_FFFF,  q: 32'd0,          r: 32'h8000_0000,  dbz: 1'b0};
        vecs[3]  = '{a: 32'd5,          b: 32'd0,          q: 32'hFFFF_FFFF,  r: 32'd5,          dbz: 1'b1};
        vecs[4]  = '{a: 32'd9,          b: 32'd3,          q: 32'd3,          r: 32'd0,          dbz: 1'b0};
        vecs[5]  = '{a: 32'd0,          b: 32'd5,          q: 32'd0,          r: 32'd0,          dbz: 1'b0};
        vecs[6]  = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  q: 32'd1,          r: 32'd0,          dbz: 1'b0};
        vecs[7]  = '{a: 32'd0,          b: 32'd0,          q: 32'hFFFF_FFFF,  r: 32'd0,          dbz: 1'b1};
        vecs[8]  = '{a: 32'h1234_5678,  b: 32'h10,         q: 32'h0123_4567,  r: 32'h8,          dbz: 1'b0};
        vecs[9]  = '{a: 32'hFFFF_FFFE,  b: 32'd2,          q: 32'h7FFF_FFFF,  r: 32'd0,          dbz: 1'b0};
        vecs[10] = '{a: 32'hDEAD_BEEF,  b: 32'h1_0000,     q: 32'hDEAD,       r: 32'hBEEF,       dbz: 1'b0};

        // Asynchronous reset, checked before any clock edge has been seen under reset.
        #2 rst_n = 1'b0;
        #1;
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset done", 64'(done), 64'(0));
        chk("reset quotient", 64'(quotient), 64'(0));
        chk("reset remainder", 64'(remainder), 64'(0));
        chk("reset div_by_zero", 64'(div_by_zero), 64'(0));
        step();
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++)
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                  mk(vecs[i].q, vecs[i].r, vecs[i].dbz));

        // Abort 1000/3 after 10 RUN cycles; outputs must clear without a clock edge.
        dividend = 32'd1000;
        divisor  = 32'd3;
        start    = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        chk("abort busy_before", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("abort busy", 64'(busy), 64'(0));
        chk("abort done", 64'(done), 64'(0));
        chk("abort quotient", 64'(quotient), 64'(0));
        chk("abort remainder", 64'(remainder), 64'(0));
        chk("abort div_by_zero", 64'(div_by_zero), 64'(0));
        step();
        rst_n = 1'b1;
        dn = 0;
        repeat (40) begin
            step();
            if (done) dn++;
        end
        chk("abort no_done", 64'(dn), 64'(0));
        $display("op abort: done pulses after reset=%0d", dn);

        // First start after reset release must be accepted immediately.
        do_op("post_reset", 32'd100, 32'd7, mk(32'd14, 32'd2, 1'b0));

        // Back-to-back issue with start held high; operands change mid-RUN.
        dividend = 32'd7;
        divisor  = 32'd100;
        start    = 1'b1;
        sb.push_back(mk(32'd0, 32'd7, 1'b0));
        sb.push_back(mk(32'd10, 32'd0, 1'b0));
        step();
        repeat (3) step();
        dividend = 32'd50;
        divisor  = 32'd5;
        n = 0;
        while (!done && n < W + 10) begin step(); n++; end
        t1 = cyc;
        chk("b2b first_latency", 64'(n), 64'(W - 3));
        if (done) check_result("b2b_first");
        step();
        step();
        start = 1'b0;
        chk("b2b second_accepted", 64'(busy), 64'(1));
        n = 0;
        while (!done && n < W + 10) begin step(); n++; end
        t2 = cyc;
        if (done) check_result("b2b_second");
        chk("b2b interval", 64'(t2 - t1), 64'(34));
        step();
        chk("b2b done_width", 64'(done), 64'(0));
        while (sb.size() > 0) void'(sb.pop_front());

        // Random pairs biased towards 0, 1 and all ones.
        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 3))
                0:       a = '0;
                1:       a = 32'd1;
                2:       a = '1;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0:       b = '0;
                1:       b = 32'd1;
                2:       b = '1;
                3:       b = 32'($urandom_range(2, 1000));
                default: b = $urandom;
            endcase
            do_op($sformatf("rnd%0d", i), a, b, model(a, b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width in bits; legal range 4..64.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request a new division; sampled only in IDLE.
REQ-005 Port: dividend  input  WIDTH  unsigned dividend; captured on the edge that accepts start.
REQ-006 Port: divisor  input  WIDTH  unsigned divisor; captured on the edge that accepts start.
REQ-007 Port: busy  output  1  high whenever the state is not IDLE.
REQ-008 Port: done  output  1  single-cycle pulse marking valid results.
REQ-009 Port: quotient  output  WIDTH  unsigned quotient of the last completed operation.
REQ-010 Port: remainder  output  WIDTH  unsigned remainder of the last completed operation.
REQ-011 Port: div_by_zero  output  1  high when the last completed operation had divisor 0.

Function
REQ-012 The block SHALL compute dividend = quotient*divisor + remainder with remainder < divisor, unsigned, by restoring shift-subtract, one quotient bit per cycle.
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 IDLE with start=1 and divisor!=0 at edge N SHALL:
- latch both operands
- load the iteration counter with WIDTH
- clear the partial remainder
- go to RUN.
REQ-015 IDLE with start=1 and divisor==0 at edge N SHALL go directly to DONE with:
- quotient = all ones
- remainder = dividend
- div_by_zero = 1.
REQ-016 Each RUN edge SHALL perform one iteration:
- shift the next dividend bit (MSB first) into the partial remainder
- compare and subtract using a WIDTH+1-bit difference so that no carry is lost
- shift the resulting quotient bit in at the LSB
- decrement the counter.
REQ-017 On the RUN edge where the counter reaches 0, the FSM SHALL go to DONE and write quotient and remainder, with div_by_zero = 0.
REQ-018 Latency: start accepted at edge N SHALL give done=1 between edges N+WIDTH and N+WIDTH+1; for divisor 0, between edges N+1 and N+2.
REQ-019 DONE SHALL last exactly one cycle and then return to IDLE unconditionally; done SHALL be high only in DONE.
REQ-020 start SHALL be ignored in RUN and DONE; operands changing during RUN SHALL NOT affect the result.
REQ-021 start held high continuously SHALL produce back-to-back operations:
- accepted again on the first IDLE edge after DONE
- giving a minimum issue interval of WIDTH+2 cycles.
REQ-022 quotient, remainder and div_by_zero SHALL change only on the edge entering DONE, and SHALL hold otherwise, including through a new RUN.
REQ-023 The intermediate quotient and remainder SHALL be kept in internal registers and SHALL NOT be visible on the outputs before done.

Reset
REQ-024 rst_n=0 SHALL immediately, without a clock edge, force:
- state to IDLE
- busy = 0, done = 0
- quotient = 0, remainder = 0, div_by_zero = 0
- all internal registers to 0.
REQ-025 Reset asserted during RUN or DONE SHALL abort the operation; no done pulse SHALL follow for the aborted operation.
REQ-026 After rst_n rises, the first start SHALL be accepted on the first rising edge at which it is sampled high.

Verification
REQ-027 100 / 7, start at edge N -> done at N+32, quotient=14, remainder=2, div_by_zero=0.
REQ-028 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0; and 0x80000000 / 0xFFFFFFFF -> quotient=0, remainder=0x80000000 (checks the WIDTH+1-bit compare).
REQ-029 5 / 0 -> done at N+1, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1; the next op 9 / 3 -> quotient=3, remainder=0, div_by_zero=0.
REQ-030 Start 1000 / 3, then rst_n=0 after 10 RUN cycles -> busy=0 and outputs 0 immediately; no done pulse within 40 cycles.
REQ-031 start held high with operands 7 / 100, changing the operands to 50 / 5 during RUN:
- first result quotient=0, remainder=7
- second op (50 / 5) accepted at the edge after DONE: quotient=10, remainder=0
- done pulses exactly 34 cycles apart.
REQ-032 Random unsigned pairs including 0, 1 and all ones, checked against a reference model -> quotient and remainder match; done is one cycle wide; busy is low only in IDLE.
